// File: rtl/nco_burst_gen.sv
// Multi-channel NCO / sine burst generator for the NMR excitation DAC path.
// All channels share one phase increment. Each channel has its own phase
// offset and amplitude. The generator runs in continuous mode, or emits a
// fixed-length burst and flags the last sample with a one-cycle done pulse.
//
// Datapath, one set per channel:
//   stage 1: phase = acc + offset, keep only the LUT address bits
//   stage 2: registered sine table read
//   stage 3: signed sample * unsigned amplitude
//   stage 4: floor shift by AMP_W-1, saturate to OUT_W, register the output
// Valid and done tags travel down the pipeline beside the data.
// PHASE_W must be larger than LUT_AW.
module nco_burst_gen #(
    parameter int NCH     = 2,
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 10,
    parameter int OUT_W   = 14,
    parameter int AMP_W   = 16,
    parameter int CNT_W   = 32
) (
    input  logic                     clk_125MHz,
    input  logic                     aresetn,
    input  logic                     en_gen,
    input  logic                     cfg_mode,
    input  logic [PHASE_W-1:0]       cfg_phase_inc,
    input  logic [NCH*PHASE_W-1:0]   cfg_phase_off,
    input  logic [NCH*AMP_W-1:0]     cfg_amplitude,
    input  logic [CNT_W-1:0]         cfg_burst_len,
    output logic [NCH*OUT_W-1:0]     out_data,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     done
);

    localparam int LUT_DEPTH = 2 ** LUT_AW;
    localparam int LO_W      = PHASE_W - LUT_AW;
    localparam int PROD_W    = OUT_W + AMP_W + 1;

    localparam logic signed [PROD_W-1:0] SAT_HI = PROD_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] SAT_LO = PROD_W'(-(2 ** (OUT_W - 1)));

    // Sine table entry k: round-half-away-from-zero of full scale * sin(2*pi*k/N).
    function automatic logic signed [OUT_W-1:0] sine_entry(input int k);
        real full_scale;
        real x;
        full_scale = real'((2 ** (OUT_W - 1)) - 1);
        x = full_scale * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(LUT_DEPTH));
        if (x >= 0.0) begin
            return OUT_W'($rtoi(x + 0.5));
        end else begin
            return OUT_W'(-$rtoi(0.5 - x));
        end
    endfunction

    // ------------------------------------------------------------------
    // Sine table, fixed at elaboration and shared by all channel readers.
    // ------------------------------------------------------------------
    logic signed [OUT_W-1:0] sine_rom [LUT_DEPTH];

    for (genvar gi = 0; gi < LUT_DEPTH; gi++) begin : g_rom
        localparam logic signed [OUT_W-1:0] ENTRY = sine_entry(gi);
        assign sine_rom[gi] = ENTRY;
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic                   en_prev_reg;
    logic                   mode_reg;
    logic [PHASE_W-1:0]     inc_reg;
    logic [NCH*PHASE_W-1:0] off_reg;
    logic [NCH*AMP_W-1:0]   amp_reg;
    logic [CNT_W-1:0]       len_reg;
    logic [PHASE_W-1:0]     acc_reg;
    logic [CNT_W-1:0]       cnt_reg;

    // Tags travelling with the data: valid marks a real sample, done marks
    // the end of a burst (it can ride alone when the burst length is zero).
    logic s1_valid_reg, s2_valid_reg, s3_valid_reg;
    logic s1_done_reg,  s2_done_reg,  s3_done_reg;
    logic out_valid_reg;
    logic done_reg;

    logic start;
    logic issue;
    logic done_tag;
    logic pipe_empty;

    assign start      = (state_reg == IDLE) && en_gen && !en_prev_reg;
    assign pipe_empty = !(s1_valid_reg || s2_valid_reg || s3_valid_reg ||
                          s1_done_reg  || s2_done_reg  || s3_done_reg);

    // Next-state logic plus the per-cycle issue and done-tag decisions.
    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        done_tag   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (mode_reg) begin
                    if (len_reg == '0) begin
                        // Empty burst: send a done tag down the pipe on its own.
                        done_tag   = 1'b1;
                        state_next = DRAIN;
                    end else begin
                        issue = 1'b1;
                        if (cnt_reg == len_reg - CNT_W'(1)) begin
                            done_tag   = 1'b1;
                            state_next = DRAIN;
                        end
                    end
                end else begin
                    if (en_gen) begin
                        issue = 1'b1;
                    end else begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pipe_empty) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and en_gen edge detector.
    always_ff @(posedge clk_125MHz or negedge aresetn) begin
        if (!aresetn) begin
            state_reg   <= IDLE;
            en_prev_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            en_prev_reg <= en_gen;
        end
    end

    // Configuration snapshot, taken only at the start edge.
    always_ff @(posedge clk_125MHz or negedge aresetn) begin
        if (!aresetn) begin
            mode_reg <= 1'b0;
            inc_reg  <= '0;
            off_reg  <= '0;
            amp_reg  <= '0;
            len_reg  <= '0;
        end else if (start) begin
            mode_reg <= cfg_mode;
            inc_reg  <= cfg_phase_inc;
            off_reg  <= cfg_phase_off;
            amp_reg  <= cfg_amplitude;
            len_reg  <= cfg_burst_len;
        end
    end

    // Phase accumulator and sample counter. Both are cleared at start and
    // advance once for every issued sample.
    always_ff @(posedge clk_125MHz or negedge aresetn) begin
        if (!aresetn) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (start) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (issue) begin
            acc_reg <= acc_reg + inc_reg;
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    // Valid and done tags shift alongside the channel datapaths.
    always_ff @(posedge clk_125MHz or negedge aresetn) begin
        if (!aresetn) begin
            s1_valid_reg  <= 1'b0;
            s2_valid_reg  <= 1'b0;
            s3_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            s1_done_reg   <= 1'b0;
            s2_done_reg   <= 1'b0;
            s3_done_reg   <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            s1_valid_reg  <= issue;
            s2_valid_reg  <= s1_valid_reg;
            s3_valid_reg  <= s2_valid_reg;
            out_valid_reg <= s3_valid_reg;
            s1_done_reg   <= done_tag;
            s2_done_reg   <= s1_done_reg;
            s3_done_reg   <= s2_done_reg;
            done_reg      <= s3_done_reg;
        end
    end

    assign out_valid = out_valid_reg;
    assign done      = done_reg;
    assign busy      = (state_reg != IDLE);

    // ------------------------------------------------------------------
    // Per-channel datapath
    // ------------------------------------------------------------------
    // Only the top LUT_AW bits of acc + offset are needed. The low bits
    // matter only through their carry into the address field.
    logic [LO_W-1:0]   acc_lo;
    logic [LUT_AW-1:0] acc_hi;

    assign acc_lo = acc_reg[LO_W-1:0];
    assign acc_hi = acc_reg[PHASE_W-1:LO_W];

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [LO_W-1:0]          off_lo;
        logic [LUT_AW-1:0]        off_hi;
        logic                     lo_carry;
        logic [LUT_AW-1:0]        addr_next;
        logic [AMP_W-1:0]         amp_ch;
        logic [LUT_AW-1:0]        addr_reg;
        logic signed [OUT_W-1:0]  lut_reg;
        logic signed [PROD_W-1:0] prod_reg;
        logic signed [PROD_W-1:0] scaled;
        logic signed [OUT_W-1:0]  sat_val;
        logic signed [OUT_W-1:0]  data_reg;

        assign off_lo    = off_reg[gi*PHASE_W +: LO_W];
        assign off_hi    = off_reg[gi*PHASE_W + LO_W +: LUT_AW];
        // acc_lo + off_lo overflows exactly when acc_lo > ~off_lo.
        assign lo_carry  = (acc_lo > ~off_lo);
        assign addr_next = acc_hi + off_hi + {{(LUT_AW-1){1'b0}}, lo_carry};
        assign amp_ch    = amp_reg[gi*AMP_W +: AMP_W];

        // Floor division by 2^(AMP_W-1), then clamp to the output range.
        assign scaled = prod_reg >>> (AMP_W - 1);

        // Saturate the scaled product to the signed OUT_W range.
        always_comb begin
            if (scaled > SAT_HI) begin
                sat_val = SAT_HI[OUT_W-1:0];
            end else if (scaled < SAT_LO) begin
                sat_val = SAT_LO[OUT_W-1:0];
            end else begin
                sat_val = scaled[OUT_W-1:0];
            end
        end

        // Four-stage sample pipeline. The output is held at zero when no
        // sample is present.
        always_ff @(posedge clk_125MHz or negedge aresetn) begin
            if (!aresetn) begin
                addr_reg <= '0;
                lut_reg  <= '0;
                prod_reg <= '0;
                data_reg <= '0;
            end else begin
                addr_reg <= addr_next;
                lut_reg  <= sine_rom[addr_reg];
                prod_reg <= lut_reg * $signed({1'b0, amp_ch});
                data_reg <= s3_valid_reg ? sat_val : '0;
            end
        end

        assign out_data[gi*OUT_W +: OUT_W] = data_reg;
    end

endmodule
